// File: rtl/latch_bank_wr_ctrl_if.sv
// Shared write-bus bundle between the two requesters and the latch-bank write controller.
interface latch_bank_wr_ctrl_if #(
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 2
);
   localparam int unsigned DEPTH = 1 << AW;

   logic [1:0]       req;
   logic [AW-1:0]    addr0;
   logic [DW-1:0]    data0;
   logic [AW-1:0]    addr1;
   logic [DW-1:0]    data1;
   logic [1:0]       gnt;
   logic [1:0]       ack;
   logic             busy;
   logic [DEPTH-1:0] le;
   logic [DW-1:0]    wdata;

   // Requester side: drives requests and write payloads, observes grant/ack and bank drive.
   modport master (
      output req, addr0, data0, addr1, data1,
      input  gnt, ack, busy, le, wdata
   );

   // Controller side.
   modport slave (
      input  req, addr0, data0, addr1, data1,
      output gnt, ack, busy, le, wdata
   );
endinterface

// File: rtl/latch_bank_wr_ctrl.sv
// Round-robin write controller for a DEPTH x DW bank of level-sensitive latches.
// Each write runs SETUP -> STROBE -> HOLD so wdata is stable around the enable pulse.
module latch_bank_wr_ctrl #(
   parameter int unsigned DW         = 8,
   parameter int unsigned AW         = 2,
   parameter int unsigned STROBE_CYC = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   latch_bank_wr_ctrl_if.slave  bus
);

   localparam int unsigned DEPTH = 1 << AW;
   localparam int unsigned CW    = 4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_STROBE = 2'd2,
      S_HOLD   = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             pref_q, pref_d;     // 1: requester 1 wins the next tie
   logic [AW-1:0]    addr_q, addr_d;
   logic [1:0]       gnt_q, gnt_d;
   logic [1:0]       ack_q, ack_d;
   logic             busy_q, busy_d;
   logic [DEPTH-1:0] le_q, le_d;
   logic [DW-1:0]    wdata_q, wdata_d;
   logic             win_c;              // arbitration winner index

   // Winner: a lone requester always wins, a tie goes to the preferred one.
   always_comb begin
      win_c = bus.req[1] & (~bus.req[0] | pref_q);
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (bus.req != 2'b00) state_d = S_SETUP;
         S_SETUP:  state_d = S_STROBE;
         S_STROBE: if (cnt_q == '0) state_d = S_HOLD;
         S_HOLD:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Output/datapath next values; everything holds unless the current state changes it.
   always_comb begin
      gnt_d   = gnt_q;
      ack_d   = ack_q;
      busy_d  = busy_q;
      le_d    = le_q;
      wdata_d = wdata_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      pref_d  = pref_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req != 2'b00) begin
               gnt_d   = win_c ? 2'b10 : 2'b01;
               addr_d  = win_c ? bus.addr1 : bus.addr0;
               wdata_d = win_c ? bus.data1 : bus.data0;
               busy_d  = 1'b1;
               pref_d  = ~win_c;
            end
         end
         S_SETUP: begin
            le_d  = DEPTH'(1) << addr_q;
            cnt_d = CW'(STROBE_CYC - 1);
         end
         S_STROBE: begin
            if (cnt_q == '0) begin
               le_d  = '0;
               ack_d = gnt_q;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_HOLD: begin
            ack_d  = '0;
            gnt_d  = '0;
            busy_d = 1'b0;
         end
         default: ;
      endcase
   end

   // Datapath and output flops; reset clears every output asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         pref_q  <= 1'b0;
         addr_q  <= '0;
         gnt_q   <= '0;
         ack_q   <= '0;
         busy_q  <= 1'b0;
         le_q    <= '0;
         wdata_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         pref_q  <= pref_d;
         addr_q  <= addr_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         le_q    <= le_d;
         wdata_q <= wdata_d;
      end
   end

   assign bus.gnt   = gnt_q;
   assign bus.ack   = ack_q;
   assign bus.busy  = busy_q;
   assign bus.le    = le_q;
   assign bus.wdata = wdata_q;

endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
// Scoreboard bench for latch_bank_wr_ctrl: one instance with STROBE_CYC=1, one with STROBE_CYC=3.
module tb_latch_bank_wr_ctrl;

   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 2;
   localparam int unsigned SC_A  = 1;
   localparam int unsigned SC_B  = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   latch_bank_wr_ctrl_if #(.DW(DW), .AW(AW)) bus_a ();
   latch_bank_wr_ctrl_if #(.DW(DW), .AW(AW)) bus_b ();

   latch_bank_wr_ctrl #(.DW(DW), .AW(AW), .STROBE_CYC(SC_A)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   latch_bank_wr_ctrl #(.DW(DW), .AW(AW), .STROBE_CYC(SC_B)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   typedef struct {
      int             owner;
      logic [AW-1:0]  addr;
      logic [DW-1:0]  data;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests   = 0;
   int   n_fail    = 0;
   bit   use_model = 1'b0;
   int   grants    = 0;
   int   acks      = 0;
   int   aborts    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] onehot(input int idx);
      logic [31:0] one;
      one = 32'd1;
      return one << idx;
   endfunction

   task automatic push_exp(input int owner, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      exp_t e;
      e.owner = owner;
      e.addr  = addr;
      e.data  = data;
      exp_q.push_back(e);
   endtask

   // Reference arbiter for the random phase: pushes the expected winner at each grant edge.
   int m_cnt  = 0;
   bit m_pref = 1'b0;
   always @(posedge clk or negedge rst_n) begin
      int w;
      w = 0;
      if (!rst_n) begin
         m_cnt  = 0;
         m_pref = 1'b0;
      end else if (m_cnt > 0) begin
         m_cnt--;
      end else if (bus_a.req != 2'b00) begin
         if (bus_a.req == 2'b11) w = m_pref ? 1 : 0;
         else                    w = bus_a.req[1] ? 1 : 0;
         m_pref = (w == 0);
         m_cnt  = SC_A + 2;
         if (use_model) begin
            if (w == 1) push_exp(1, bus_a.addr1, bus_a.data1);
            else        push_exp(0, bus_a.addr0, bus_a.data0);
         end
      end
   end

   // Monitor for instance A: pops an expectation on every new grant and tracks it to ack.
   logic [1:0]    p_gnt   = '0;
   logic [1:0]    p_ack   = '0;
   logic [3:0]    p_le    = '0;
   logic [DW-1:0] p_wdata = '0;
   int            cyc     = 0;
   int            t_gnt   = 0;
   int            le_len  = 0;
   bit            have_cur = 1'b0;
   exp_t          cur;

   always @(negedge clk) begin
      if (!rst_n) begin
         if (have_cur) aborts++;
         have_cur = 1'b0;
         p_gnt    = '0;
         p_ack    = '0;
         p_le     = '0;
         p_wdata  = '0;
         le_len   = 0;
      end else begin
         cyc++;
         check("le_onehot0", 32'($onehot0(bus_a.le)), 32'd1);
         if (bus_a.le != '0) begin
            check("wdata_stable_le", 32'(bus_a.wdata), 32'(p_wdata));
            check("busy_with_le", 32'(bus_a.busy), 32'd1);
         end
         if (p_gnt == '0 && bus_a.gnt != '0) begin
            grants++;
            if (exp_q.size() == 0) begin
               check("grant_expected", 32'(exp_q.size()), 32'd1);
            end else begin
               cur      = exp_q.pop_front();
               have_cur = 1'b1;
               t_gnt    = cyc;
               le_len   = 0;
               check("gnt_owner", 32'(bus_a.gnt), onehot(cur.owner));
               check("gnt_wdata", 32'(bus_a.wdata), 32'(cur.data));
               check("setup_le_zero", 32'(bus_a.le), 32'd0);
               check("gnt_busy", 32'(bus_a.busy), 32'd1);
            end
         end
         if (bus_a.le != '0) begin
            if (p_le == '0 && have_cur) begin
               check("le_start_cycle", 32'(cyc), 32'(t_gnt + 1));
               check("le_addr", 32'(bus_a.le), onehot(int'(cur.addr)));
            end
            le_len++;
         end
         if (bus_a.ack != '0) begin
            acks++;
            if (!have_cur) begin
               check("ack_expected", 32'(have_cur), 32'd1);
            end else begin
               check("ack_owner", 32'(bus_a.ack), onehot(cur.owner));
               check("ack_gnt", 32'(bus_a.gnt), onehot(cur.owner));
               check("strobe_len", 32'(le_len), 32'(SC_A));
               check("ack_cycle", 32'(cyc), 32'(t_gnt + 1 + int'(SC_A)));
               check("ack_wdata", 32'(bus_a.wdata), 32'(cur.data));
               check("ack_le_zero", 32'(bus_a.le), 32'd0);
               have_cur = 1'b0;
            end
         end
         if (p_ack != '0) begin
            check("post_ack_ack", 32'(bus_a.ack), 32'd0);
            check("post_ack_gnt", 32'(bus_a.gnt), 32'd0);
            check("post_ack_busy", 32'(bus_a.busy), 32'd0);
         end
         p_gnt   = bus_a.gnt;
         p_ack   = bus_a.ack;
         p_le    = bus_a.le;
         p_wdata = bus_a.wdata;
      end
   end

   // Bounded wait on instance A: kind 0 = ack[who], kind 1 = any le bit.
   task automatic wait_a(input int kind, input int who, input string name);
      int  k;
      bit  hit;
      hit = 1'b0;
      for (k = 0; k < 40; k++) begin
         @(negedge clk);
         if (kind == 0 && bus_a.ack[who]) hit = 1'b1;
         if (kind == 1 && bus_a.le != '0) hit = 1'b1;
         if (hit) break;
      end
      check(name, 32'(hit), 32'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Expected per-cycle view of instance B after a single write to address 3.
   int b_gnt [6] = '{1, 1, 1, 1, 1, 0};
   int b_le  [6] = '{0, 8, 8, 8, 0, 0};
   int b_ack [6] = '{0, 0, 0, 0, 1, 0};
   int b_busy[6] = '{1, 1, 1, 1, 1, 0};

   initial begin
      bus_a.req = '0; bus_a.addr0 = '0; bus_a.data0 = '0; bus_a.addr1 = '0; bus_a.data1 = '0;
      bus_b.req = '0; bus_b.addr0 = '0; bus_b.data0 = '0; bus_b.addr1 = '0; bus_b.data1 = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_gnt",   32'(bus_a.gnt),   32'd0);
      check("rst_ack",   32'(bus_a.ack),   32'd0);
      check("rst_busy",  32'(bus_a.busy),  32'd0);
      check("rst_le",    32'(bus_a.le),    32'd0);
      check("rst_wdata", 32'(bus_a.wdata), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single write: requester 0, addr 2, data A5.
      push_exp(0, 2'd2, 8'hA5);
      bus_a.addr0 = 2'd2; bus_a.data0 = 8'hA5; bus_a.req = 2'b01;
      wait_a(0, 0, "t1_ack_seen");
      bus_a.req = 2'b00;
      @(negedge clk);

      // Contention from reset: 0 first, 1 next, then tie goes back to 0, then 1 back-to-back.
      do_reset();
      push_exp(0, 2'd1, 8'h11);
      push_exp(1, 2'd3, 8'h22);
      bus_a.addr0 = 2'd1; bus_a.data0 = 8'h11; bus_a.addr1 = 2'd3; bus_a.data1 = 8'h22;
      bus_a.req = 2'b11;
      wait_a(0, 0, "c1_ack_seen");
      bus_a.req = 2'b10;
      wait_a(0, 1, "c2_ack_seen");
      push_exp(0, 2'd0, 8'h33);
      push_exp(1, 2'd2, 8'h44);
      bus_a.addr0 = 2'd0; bus_a.data0 = 8'h33; bus_a.addr1 = 2'd2; bus_a.data1 = 8'h44;
      bus_a.req = 2'b11;
      wait_a(0, 0, "c3_ack_seen");
      bus_a.req = 2'b10;
      wait_a(0, 1, "c4_ack_seen");
      bus_a.req = 2'b00;
      @(negedge clk);

      // Owner drops req and changes addr/data mid-strobe; captured values must win.
      push_exp(0, 2'd0, 8'h3C);
      bus_a.addr0 = 2'd0; bus_a.data0 = 8'h3C; bus_a.req = 2'b01;
      wait_a(1, 0, "d1_le_seen");
      bus_a.req = 2'b00; bus_a.addr0 = 2'd1; bus_a.data0 = 8'hFF;
      wait_a(0, 0, "d2_ack_seen");
      @(negedge clk);

      // Reset mid-strobe: outputs clear before the next edge, then lone requester 1 wins.
      push_exp(0, 2'd1, 8'h77);
      bus_a.addr0 = 2'd1; bus_a.data0 = 8'h77; bus_a.req = 2'b01;
      wait_a(1, 0, "r1_le_seen");
      rst_n = 1'b0;
      #1;
      check("mid_rst_le",    32'(bus_a.le),    32'd0);
      check("mid_rst_gnt",   32'(bus_a.gnt),   32'd0);
      check("mid_rst_ack",   32'(bus_a.ack),   32'd0);
      check("mid_rst_busy",  32'(bus_a.busy),  32'd0);
      check("mid_rst_wdata", 32'(bus_a.wdata), 32'd0);
      bus_a.req = 2'b10; bus_a.addr1 = 2'd2; bus_a.data1 = 8'h5A;
      push_exp(1, 2'd2, 8'h5A);
      @(negedge clk);
      rst_n = 1'b1;
      wait_a(0, 1, "r2_ack_seen");
      bus_a.req = 2'b00;
      @(negedge clk);

      // STROBE_CYC=3 instance: write C3 to addr 3, check each cycle against the table.
      bus_b.addr0 = 2'd3; bus_b.data0 = 8'hC3; bus_b.req = 2'b01;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("b_gnt_%0d", i),   32'(bus_b.gnt),   32'(b_gnt[i]));
         check($sformatf("b_le_%0d", i),    32'(bus_b.le),    32'(b_le[i]));
         check($sformatf("b_ack_%0d", i),   32'(bus_b.ack),   32'(b_ack[i]));
         check($sformatf("b_busy_%0d", i),  32'(bus_b.busy),  32'(b_busy[i]));
         check($sformatf("b_wdata_%0d", i), 32'(bus_b.wdata), 32'h0000_00C3);
         if (i == 4) bus_b.req = 2'b00;
      end

      // Random traffic on instance A with the reference arbiter supplying expectations.
      do_reset();
      use_model = 1'b1;
      repeat (1000) begin
         @(negedge clk);
         bus_a.req   = 2'($urandom);
         bus_a.addr0 = 2'($urandom);
         bus_a.data0 = 8'($urandom);
         bus_a.addr1 = 2'($urandom);
         bus_a.data1 = 8'($urandom);
      end
      @(negedge clk);
      bus_a.req = 2'b00;
      repeat (10) @(negedge clk);
      use_model = 1'b0;

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("grant_ack_balance", 32'(acks + aborts), 32'(grants));
      check("one_abort", 32'(aborts), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/latch_bank_wr_ctrl.md
Name: latch_bank_wr_ctrl

Overview:
- Write controller and arbiter for a bank of level-sensitive D latches (DEPTH words x DW bits) in the memory subsystem.
- Two requesters share the bank's common data bus. The block grants one requester at a time, round-robin.
- For each write it sequences a glitch-free setup -> enable -> hold pulse on exactly one latch enable, so data never changes while any latch is transparent.

Parameters:
- DW, 8, data width of each latch word and of the shared write bus.
- AW, 2, address width; DEPTH = 2**AW latch words.
- STROBE_CYC, 1, cycles the selected latch enable stays high; legal range 1..15.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  2  write request per requester; held high until that requester's ack.
- addr0  input  AW  requester 0 target word.
- data0  input  DW  requester 0 write data.
- addr1  input  AW  requester 1 target word.
- data1  input  DW  requester 1 write data.
- gnt  output  2  one-hot current owner; 0 when idle.
- ack  output  2  one-cycle completion pulse to the owner.
- busy  output  1  high while a write is in progress.
- le  output  DEPTH  one-hot latch enables to the bank; at most one bit high.
- wdata  output  DW  shared data to all latch D inputs.

Behaviour:
- Output timing:
  - All outputs come directly from flops, with no combinational path from inputs.
  - On rst_n low, all outputs go to 0 immediately, regardless of clk.
  - On rst_n low, the FSM goes to IDLE and the round-robin pointer resets to "requester 0 preferred".
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - If req != 0 at an edge, arbitrate and capture the winner's addr/data.
  - Set gnt, wdata = captured data, busy = 1, and go to SETUP. le stays 0.
- SETUP (1 cycle):
  - wdata is stable and le = 0.
  - Next edge: le <= onehot(captured addr), load the strobe counter, go to STROBE.
- STROBE (STROBE_CYC cycles): le is held at onehot(addr) and wdata is held.
- HOLD (1 cycle):
  - Entered with le <= 0 and ack[owner] <= 1; wdata is still held.
  - Next edge: ack <= 0, gnt <= 0, busy <= 0, go to IDLE. wdata keeps its last value.
- Latency:
  - A request sampled at edge E0 gives le high from E1 to E1+STROBE_CYC.
  - ack is high from E1+STROBE_CYC to E2+STROBE_CYC.
  - The controller is back in IDLE after STROBE_CYC+3 edges.
  - The earliest next grant is at the first edge in IDLE, so there is 1 idle cycle between transactions.
- Arbitration:
  - When both requesters request, the one not granted last wins.
  - When only one requests, it wins regardless of the pointer.
  - The pointer updates only when a grant is made.
- Boundary rules:
  - req dropped by the owner mid-transaction is ignored; the write completes and ack still pulses.
  - req changes from the non-owner during a transaction are ignored until IDLE.
  - addr/data changes after capture have no effect.
  - The same requester holding req through ack (back-to-back) is treated as a new request at the next IDLE edge.
  - Invariants: le is never nonzero outside STROBE; wdata never changes while le != 0.
  - Reset asserted mid-STROBE drops le to 0 asynchronously; the partially written latch content is undefined and no ack is issued.

Test Plan:
- Single write, STROBE_CYC=1: req=01, addr0=2, data0=8'hA5 at E0 -> wdata=A5 from E1, le=4'b0100 for 1 cycle (E1-E2), ack=01 for E2-E3, busy low after E3.
- Contention: req=11 from reset -> requester 0 served first (gnt=01). Keeping req1 high -> requester 1 granted at the first IDLE edge after ack0 (gnt=10). Then req=11 again -> requester 0 wins.
- STROBE_CYC=3: one write to addr 3 -> le=4'b1000 for exactly 3 cycles; wdata constant throughout SETUP/STROBE/HOLD; ack exactly 1 cycle.
- Owner drops req during STROBE; data0/addr0 are also changed -> write completes with the originally captured address/data, and ack still pulses.
- rst_n low mid-STROBE -> le, gnt, ack, busy, wdata read 0 before the next clk edge. After release, req=10 is granted immediately (pointer reset prefers 0, but only 1 requests).
- Invariant checks over 1000 random req/addr/data cycles: onehot0(le) always holds; wdata is stable whenever le != 0; every grant gets exactly one ack.
